// File: rtl/fd_skid_reg_if.sv
// fd_skid_reg_if: fetch-side and decode-side handshake/payload bundle for the
// F->D skid register. Master is the environment (F, D, hazard unit); slave is
// the pipeline register itself.
interface fd_skid_reg_if #(
    parameter int EXC_W = 5
);
    // fetch side
    logic             f_valid;
    logic             f_ready;
    logic [31:0]      f_pc;
    logic [31:0]      f_instr;
    logic             f_bd;
    logic [EXC_W-1:0] f_exc;
    // control
    logic             flush;
    // decode side
    logic             d_ready;
    logic             d_valid;
    logic [31:0]      d_pc;
    logic [31:0]      d_instr;
    logic             d_bd;
    logic [EXC_W-1:0] d_exc;

    modport master (
        output f_valid, f_pc, f_instr, f_bd, f_exc, flush, d_ready,
        input  f_ready, d_valid, d_pc, d_instr, d_bd, d_exc
    );

    modport slave (
        input  f_valid, f_pc, f_instr, f_bd, f_exc, flush, d_ready,
        output f_ready, d_valid, d_pc, d_instr, d_bd, d_exc
    );
endinterface

// File: rtl/fd_skid_reg.sv
// fd_skid_reg: F->D pipeline register with a two-entry skid buffer.
// MAIN always feeds the decode stage; SKID catches the one word that F may
// push in the same cycle D stalls, which is what lets f_ready be a flop.
module fd_skid_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          EXC_W    = 5
) (
    input  logic         clk,
    input  logic         reset,
    fd_skid_reg_if.slave bus
);
    // One fetched instruction; all fields always move together.
    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic             bd;
        logic [EXC_W-1:0] exc;
    } fd_word_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_t;

    state_t   state_q,   state_d;
    logic     f_ready_q, f_ready_d;
    fd_word_t main_q,    main_d;
    fd_word_t skid_q,    skid_d;
    fd_word_t f_word;
    logic     d_live;
    logic     push;
    logic     pop;

    // Pack the incoming fetch fields into a single word.
    always_comb begin
        f_word       = '0;
        f_word.pc    = bus.f_pc;
        f_word.instr = bus.f_instr;
        f_word.bd    = bus.f_bd;
        f_word.exc   = bus.f_exc;
    end

    assign d_live = (state_q != ST_EMPTY);
    assign push   = bus.f_valid & f_ready_q;
    assign pop    = d_live & bus.d_ready;

    // Occupancy FSM and payload steering. f_ready_d follows the next state so
    // F sees ready drop on exactly the edge the skid entry fills.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            // Drop everything, including a push arriving this cycle. Payload
            // is left stale; output masking keeps it invisible.
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        main_d  = f_word;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_d = f_word;
                    end else if (push) begin
                        state_d = ST_TWO;
                        skid_d  = f_word;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // f_ready is low here, so only a pop can move things.
                    if (pop) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        f_ready_d = (state_d != ST_TWO);
    end

    // State, ready and payload registers; reset clears both entries at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            f_ready_q   <= 1'b1;
            main_q      <= '0;
            main_q.pc   <= RESET_PC;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            f_ready_q   <= f_ready_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
        end
    end

    // d_pc is left unmasked; the rest reads as a nop when nothing is live.
    assign bus.f_ready = f_ready_q;
    assign bus.d_valid = d_live;
    assign bus.d_pc    = main_q.pc;
    assign bus.d_instr = d_live ? main_q.instr : 32'h0;
    assign bus.d_bd    = d_live ? main_q.bd    : 1'b0;
    assign bus.d_exc   = d_live ? main_q.exc   : '0;
endmodule

// File: tb/tb_fd_skid_reg.sv
// tb_fd_skid_reg: directed vector table plus hand sequences for reset and a
// randomized queue-model run for the F->D skid register.
module tb_fd_skid_reg;
    localparam int          EXC_W  = 5;
    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fd_skid_reg_if #(.EXC_W(EXC_W)) bus ();

    fd_skid_reg #(.RESET_PC(RST_PC), .EXC_W(EXC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic             fv;
        logic [31:0]      pc;
        logic             bd;
        logic [EXC_W-1:0] exc;
        logic             fl;
        logic             dr;
        logic             e_dv;
        logic             e_fr;
        logic             chk_pc;
        logic [31:0]      e_pc;
        logic [31:0]      e_instr;
        logic             e_bd;
        logic [EXC_W-1:0] e_exc;
    } vec_t;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic             bd;
        logic [EXC_W-1:0] exc;
    } word_t;

    vec_t  vecs[$];
    word_t q[$];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    function automatic vec_t mk(input logic fv, input logic [31:0] pc, input logic bd,
                                input logic [EXC_W-1:0] exc, input logic fl, input logic dr,
                                input logic e_dv, input logic e_fr, input logic chk_pc,
                                input logic [31:0] e_pc, input logic [31:0] e_instr,
                                input logic e_bd, input logic [EXC_W-1:0] e_exc);
        vec_t v;
        v.fv = fv; v.pc = pc; v.bd = bd; v.exc = exc; v.fl = fl; v.dr = dr;
        v.e_dv = e_dv; v.e_fr = e_fr; v.chk_pc = chk_pc; v.e_pc = e_pc;
        v.e_instr = e_instr; v.e_bd = e_bd; v.e_exc = e_exc;
        return v;
    endfunction

    task automatic drive(input logic fv, input logic [31:0] pc, input logic bd,
                         input logic [EXC_W-1:0] exc, input logic fl, input logic dr);
        bus.f_valid = fv;
        bus.f_pc    = pc;
        bus.f_instr = instr_of(pc);
        bus.f_bd    = bd;
        bus.f_exc   = exc;
        bus.flush   = fl;
        bus.d_ready = dr;
    endtask

    task automatic check(input string nm, input logic e_dv, input logic e_fr, input logic chk_pc,
                         input logic [31:0] e_pc, input logic [31:0] e_instr,
                         input logic e_bd, input logic [EXC_W-1:0] e_exc);
        logic ok;
        n_tests++;
        ok = (bus.d_valid === e_dv) && (bus.f_ready === e_fr) &&
             (!chk_pc || bus.d_pc === e_pc) && (bus.d_instr === e_instr) &&
             (bus.d_bd === e_bd) && (bus.d_exc === e_exc);
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got dv=%b fr=%b pc=%h instr=%h bd=%b exc=%0d, want dv=%b fr=%b pc=%h(chk=%b) instr=%h bd=%b exc=%0d",
                     nm, bus.d_valid, bus.f_ready, bus.d_pc, bus.d_instr, bus.d_bd, bus.d_exc,
                     e_dv, e_fr, e_pc, chk_pc, e_instr, e_bd, e_exc);
        end
    endtask

    initial begin
        // fv pc bd exc fl dr | dv fr chk pc instr bd exc
        // streaming at full rate
        vecs.push_back(mk(1, 32'h3000, 0, 0, 0, 1,  1, 1, 1, 32'h3000, 32'hC0DE3000, 0, 0));
        vecs.push_back(mk(1, 32'h3004, 0, 0, 0, 1,  1, 1, 1, 32'h3004, 32'hC0DE3004, 0, 0));
        vecs.push_back(mk(1, 32'h3008, 0, 0, 0, 1,  1, 1, 1, 32'h3008, 32'hC0DE3008, 0, 0));
        vecs.push_back(mk(0, 32'h0,    0, 0, 0, 1,  0, 1, 1, 32'h3008, 32'h0,        0, 0));
        // stall fills SKID, then drains in order
        vecs.push_back(mk(1, 32'h3000, 0, 0, 0, 0,  1, 1, 1, 32'h3000, 32'hC0DE3000, 0, 0));
        vecs.push_back(mk(1, 32'h3004, 0, 0, 0, 0,  1, 0, 1, 32'h3000, 32'hC0DE3000, 0, 0));
        vecs.push_back(mk(1, 32'h3008, 0, 0, 0, 0,  1, 0, 1, 32'h3000, 32'hC0DE3000, 0, 0));
        vecs.push_back(mk(1, 32'h3008, 0, 0, 0, 0,  1, 0, 1, 32'h3000, 32'hC0DE3000, 0, 0));
        vecs.push_back(mk(1, 32'h3008, 0, 0, 0, 1,  1, 1, 1, 32'h3004, 32'hC0DE3004, 0, 0));
        vecs.push_back(mk(1, 32'h3008, 0, 0, 0, 1,  1, 1, 1, 32'h3008, 32'hC0DE3008, 0, 0));
        vecs.push_back(mk(0, 32'h0,    0, 0, 0, 1,  0, 1, 1, 32'h3008, 32'h0,        0, 0));
        // flush from TWO with F still presenting 0x3010
        vecs.push_back(mk(1, 32'h300C, 0, 0, 0, 0,  1, 1, 1, 32'h300C, 32'hC0DE300C, 0, 0));
        vecs.push_back(mk(1, 32'h3010, 0, 0, 0, 0,  1, 0, 1, 32'h300C, 32'hC0DE300C, 0, 0));
        vecs.push_back(mk(1, 32'h3010, 0, 0, 1, 0,  0, 1, 0, 32'h0,    32'h0,        0, 0));
        vecs.push_back(mk(0, 32'h0,    0, 0, 0, 1,  0, 1, 0, 32'h0,    32'h0,        0, 0));
        // flush in ONE discards a same-cycle push
        vecs.push_back(mk(1, 32'h3014, 0, 0, 0, 0,  1, 1, 1, 32'h3014, 32'hC0DE3014, 0, 0));
        vecs.push_back(mk(1, 32'h3018, 0, 0, 1, 1,  0, 1, 0, 32'h0,    32'h0,        0, 0));
        vecs.push_back(mk(0, 32'h0,    0, 0, 0, 1,  0, 1, 0, 32'h0,    32'h0,        0, 0));
        // AdEL word with delay-slot flag routed through SKID
        vecs.push_back(mk(1, 32'h3020, 0, 0, 0, 0,  1, 1, 1, 32'h3020, 32'hC0DE3020, 0, 0));
        vecs.push_back(mk(1, 32'h3002, 1, 4, 0, 0,  1, 0, 1, 32'h3020, 32'hC0DE3020, 0, 0));
        vecs.push_back(mk(0, 32'h0,    0, 0, 0, 1,  1, 1, 1, 32'h3002, 32'hC0DE3002, 1, 4));
        vecs.push_back(mk(0, 32'h0,    0, 0, 0, 1,  0, 1, 1, 32'h3002, 32'h0,        0, 0));
        // f_* ignored without f_valid; outputs stay masked
        vecs.push_back(mk(0, 32'h3030, 1, 7, 0, 1,  0, 1, 1, 32'h3002, 32'h0,        0, 0));

        // reset state
        reset = 1'b1;
        drive(0, 32'h0, 0, 0, 0, 0);
        #12;
        check("reset_state", 0, 1, 1, RST_PC, 32'h0, 0, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].fv, vecs[i].pc, vecs[i].bd, vecs[i].exc, vecs[i].fl, vecs[i].dr);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vecs[i].e_dv, vecs[i].e_fr, vecs[i].chk_pc,
                  vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_bd, vecs[i].e_exc);
        end

        // async reset while TWO is full
        drive(1, 32'h3040, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(1, 32'h3044, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("pre_reset_two", 1, 0, 1, 32'h3040, 32'hC0DE3040, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("async_reset", 0, 1, 1, RST_PC, 32'h0, 0, 0);
        @(posedge clk); #3;
        reset = 1'b0;
        drive(1, 32'h3048, 0, 0, 0, 1);
        @(posedge clk); #1;
        check("first_push_after_reset", 1, 1, 1, 32'h3048, 32'hC0DE3048, 0, 0);
        drive(0, 32'h0, 0, 0, 0, 1);
        @(posedge clk); #1;
        check("no_stale_after_reset", 0, 1, 1, 32'h3048, 32'h0, 0, 0);

        // randomized run against a queue model (DUT is EMPTY here)
        begin
            logic [31:0] next_pc;
            next_pc = 32'h0001_0000;
            q.delete();
            for (int c = 0; c < 10000; c++) begin
                logic fv, dr, fl, ok, m_push, m_pop;
                logic bd;
                logic [EXC_W-1:0] exc;
                word_t w;
                fv  = ($urandom_range(0, 3) != 0);
                dr  = ($urandom_range(0, 3) != 0);
                fl  = ($urandom_range(0, 31) == 0);
                bd  = $urandom_range(0, 1);
                exc = EXC_W'($urandom_range(0, 31));
                drive(fv, next_pc, bd, exc, fl, dr);
                w.pc = next_pc; w.instr = instr_of(next_pc); w.bd = bd; w.exc = exc;
                m_push = fv && (q.size() < 2);
                m_pop  = (q.size() > 0) && dr;
                if (fl) begin
                    q.delete();
                end else begin
                    if (m_pop)  void'(q.pop_front());
                    if (m_push) q.push_back(w);
                end
                if (m_push) next_pc = next_pc + 32'd4;
                @(posedge clk); #1;
                n_tests++;
                if (q.size() > 0)
                    ok = bus.d_valid === 1'b1 && bus.f_ready === (q.size() < 2) &&
                         bus.d_pc === q[0].pc && bus.d_instr === q[0].instr &&
                         bus.d_bd === q[0].bd && bus.d_exc === q[0].exc;
                else
                    ok = bus.d_valid === 1'b0 && bus.f_ready === 1'b1 &&
                         bus.d_instr === 32'h0 && bus.d_bd === 1'b0 && bus.d_exc === '0;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL rand_c%0d: got dv=%b fr=%b pc=%h instr=%h bd=%b exc=%0d, want occ=%0d pc=%h",
                             c, bus.d_valid, bus.f_ready, bus.d_pc, bus.d_instr, bus.d_bd, bus.d_exc,
                             q.size(), (q.size() > 0) ? q[0].pc : 32'h0);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
